pid_multi_ctrl: RTL and testbench
=================================

Name: pid_multi_ctrl

Overview:
- Multi-channel, parametrised successor to the single-motor traction RPM PID.
- Runs N_CH independent PI loops, evaluated one channel at a time on a shared datapath, on a programmable control tick.
- Improvements over the single loop: fixed-point gains, integrator clamp with conditional-integration anti-windup, tick-overrun detection, registered sign/magnitude PWM plus direction outputs per channel.
- All setpoints, gains and control are set through an Avalon-MM slave from the control base.

Parameters:
- N_CH, 4, number of motor channels (1..14).
- W_RPM, 16, signed width of setpoint and measured RPM.
- W_PWM, 8, PWM command width.
- PWM_MAX, 249, saturation magnitude of the PWM command.
- W_INT, 32, signed integrator width.
- INT_LIM, 1048576, integrator clamp magnitude (symmetric).
- FRAC, 8, gain fractional bits; u = (kp*err + ki*integ) >>> FRAC.
- PRESC_DEFAULT, 50000, reset value of the tick period in clk cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rpm_meas  in  N_CH*W_RPM  measured RPM per channel, signed, channel c at [c*W_RPM +: W_RPM].
- avs_address  in  6  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed read latency 1.
- pwm_cmd  out  N_CH*W_PWM  PWM magnitude per channel.
- dir_a  out  N_CH  direction A per channel.
- dir_b  out  N_CH  direction B per channel.
- update_pulse  out  1  one-cycle pulse after the last channel is written.

Behaviour:
- Register map (word addresses):
  - 0 CTRL: bit0 enable; bits31:16 prescale.
  - 1 STATUS: bit0 busy (RO); bit1 overrun (sticky, write-1-to-clear).
  - 8+4c SETPOINT[c]: low W_RPM bits, sign-extended on read.
  - 9+4c KP[c]: signed 16.
  - 10+4c KI[c]: signed 16.
  - 11+4c INTEG[c]: read-only.
  - Unmapped reads return 0; unmapped writes are ignored.
- No waitrequest; every access completes in one cycle. readdata is registered on the cycle after avs_read and holds until the next read.
- Reset values:
  - pwm_cmd = 0; dir_a = dir_b = all 1 (brake); update_pulse = 0; readdata = 0.
  - All setpoints, gains and integrators = 0.
  - enable = 0; prescale = PRESC_DEFAULT; overrun = 0.
- Prescaler:
  - While enabled, counts 0..prescale-1 and issues a tick on the wrap.
  - A prescale value of 0 is treated as 1.
- FSM states and transitions:
  - IDLE -> LOAD on tick.
  - LOAD: latch sp, meas, kp, ki, integ for channel ch.
  - MUL: form products.
  - SUM: sum, shift, saturate.
  - WRITE: update this channel's outputs and integrator; go to LOAD for ch+1, or to IDLE with update_pulse after ch = N_CH-1.
  - Each channel takes 4 cycles; tick-to-update_pulse = 4*N_CH+1 cycles.
- Tick while busy: the tick is dropped, overrun is set, and the current sweep continues.
- Register writes land immediately; a channel sees new values at its next LOAD.
- Arithmetic:
  - err = sp - meas, W_RPM+1 bits signed.
  - Products are full width; the accumulator is W_INT+W_RPM+2 bits.
  - u = (kp*err + ki*integ_old) >>> FRAC, arithmetic shift.
- Outputs per channel (evaluated at WRITE):
  - sp == 0: pwm = 0; dir = 11 (brake); integ = 0.
  - Otherwise u > 0: dir_a/dir_b = 1/0; pwm = min(u, PWM_MAX).
  - Otherwise u < 0: dir_a/dir_b = 0/1; pwm = min(-u, PWM_MAX).
  - Otherwise u == 0: pwm = 0; dir = 11.
- Integrator (sp != 0): integ_new = clamp(integ + err, ±INT_LIM).
  - Anti-windup: skip the update when |u| > PWM_MAX and err has the same sign as u.
- enable written 0:
  - FSM aborts to IDLE on the next cycle; prescaler is cleared.
  - All pwm = 0 and dir = 11; all integrators cleared.
  - Registers other than integrators are kept.
- reset_n asserted mid-sweep: every register returns immediately to its reset value.

Decomposition:
- Package pid_pkg holds:
  - Register offsets (CTRL, STATUS, CH_BASE, CH_STRIDE, per-channel offsets).
  - FSM state enum {IDLE, LOAD, MUL, SUM, WRITE}.
  - Derived accumulator width.
  - Saturation and clamp helper functions.
- Sub-module pid_ch_datapath: one channel's pipelined err/multiply/shift/saturate/anti-windup logic, with registered stage enables from the FSM. The top level keeps the register file, prescaler, FSM and output registers.

Test Plan:
- Proportional step: N_CH=4, kp0=256, ki0=0, sp0=100, meas0=0, enable, prescale=100 -> after the first tick pwm0=100, dir_a0/dir_b0=1/0, update_pulse 17 cycles after the tick.
- Negative saturation: sp1=-1000, kp1=256 -> pwm1=249, dir=01; the other channels are unaffected.
- Brake and clear: after integ2 builds to nonzero, write sp2=0 -> next sweep gives pwm2=0, dir=11, INTEG[2] reads 0.
- Anti-windup: kp3=0, ki3=256, sp3=1000, meas=0 for 10 ticks -> integ grows 1000 per tick until |u|>249, then stays frozen (reads 1000); never exceeds INT_LIM.
- Overrun: prescale=3 with N_CH=4 -> STATUS.overrun=1 and the sweep still completes; writing 2 to STATUS clears it.
- Async reset mid-sweep: pulse reset_n low during MUL of ch1 -> all pwm=0, dir=11, CTRL reads PRESC_DEFAULT<<16, and a read returns data on the next cycle only.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared definitions for the multi-channel PI controller: register map,
// sweep states and the saturation/clamp arithmetic helpers.
package pid_pkg;

   localparam int unsigned ADDR_CTRL   = 0;
   localparam int unsigned ADDR_STATUS = 1;
   localparam int unsigned CH_BASE     = 8;
   localparam int unsigned CH_STRIDE   = 4;

   localparam logic [1:0] OFS_SP    = 2'd0;
   localparam logic [1:0] OFS_KP    = 2'd1;
   localparam logic [1:0] OFS_KI    = 2'd2;
   localparam logic [1:0] OFS_INTEG = 2'd3;

   typedef enum logic [2:0] {IDLE, LOAD, MUL, SUM, WRITE} state_t;

   function automatic int acc_width(input int w_int, input int w_rpm);
      return w_int + w_rpm + 2;
   endfunction

   function automatic logic signed [63:0] abs_s(input logic signed [63:0] v);
      return v[63] ? -v : v;
   endfunction

   function automatic logic signed [63:0] sat_abs(input logic signed [63:0] v,
                                                  input logic signed [63:0] lim);
      logic signed [63:0] a;
      a = abs_s(v);
      return (a > lim) ? lim : a;
   endfunction

   function automatic logic signed [63:0] clamp_s(input logic signed [63:0] v,
                                                  input logic signed [63:0] lim);
      if (v > lim)       return lim;
      else if (v < -lim) return -lim;
      else               return v;
   endfunction

endpackage

// File: rtl/pid_ch_datapath.sv
// Shared per-channel PI datapath: error, products, shifted sum, then the
// output/integrator decision evaluated from the stage registers at WRITE.
module pid_ch_datapath import pid_pkg::*; #(
   parameter int W_RPM   = 16,
   parameter int W_PWM   = 8,
   parameter int PWM_MAX = 249,
   parameter int W_INT   = 32,
   parameter int INT_LIM = 1048576,
   parameter int FRAC    = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ld_en,
   input  logic                    mul_en,
   input  logic                    sum_en,
   input  logic signed [W_RPM-1:0] sp,
   input  logic signed [W_RPM-1:0] meas,
   input  logic signed [15:0]      kp,
   input  logic signed [15:0]      ki,
   input  logic signed [W_INT-1:0] integ,
   output logic [W_PWM-1:0]        pwm,
   output logic                    dir_a,
   output logic                    dir_b,
   output logic signed [W_INT-1:0] integ_new
);
   localparam int ACC_W = acc_width(W_INT, W_RPM);
   localparam int PKP_W = W_RPM + 17;
   localparam int PKI_W = W_INT + 16;

   logic signed [W_RPM-1:0] sp_q;
   logic signed [W_RPM:0]   err_q;
   logic signed [15:0]      kp_q, ki_q;
   logic signed [W_INT-1:0] integ_q;
   logic signed [PKP_W-1:0] p_kp;
   logic signed [PKI_W-1:0] p_ki;
   logic signed [ACC_W-1:0] u_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp_q    <= '0;
         err_q   <= '0;
         kp_q    <= '0;
         ki_q    <= '0;
         integ_q <= '0;
         p_kp    <= '0;
         p_ki    <= '0;
         u_q     <= '0;
      end else begin
         if (ld_en) begin
            sp_q    <= sp;
            err_q   <= {sp[W_RPM-1], sp} - {meas[W_RPM-1], meas};
            kp_q    <= kp;
            ki_q    <= ki;
            integ_q <= integ;
         end
         if (mul_en) begin
            p_kp <= PKP_W'(kp_q) * PKP_W'(err_q);
            p_ki <= PKI_W'(ki_q) * PKI_W'(integ_q);
         end
         if (sum_en)
            u_q <= (ACC_W'(p_kp) + ACC_W'(p_ki)) >>> FRAC;
      end
   end

   logic u_pos, u_neg, err_pos, err_neg, over, hold;

   always_comb begin
      u_pos   = !u_q[ACC_W-1] && (u_q != '0);
      u_neg   = u_q[ACC_W-1];
      err_pos = !err_q[W_RPM] && (err_q != '0);
      err_neg = err_q[W_RPM];
      over    = abs_s(64'(u_q)) > 64'(PWM_MAX);
      // conditional integration: freeze while saturated in the direction err pushes
      hold    = over && ((u_pos && err_pos) || (u_neg && err_neg));
      pwm       = '0;
      dir_a     = 1'b1;
      dir_b     = 1'b1;
      integ_new = '0;
      if (sp_q != '0) begin
         pwm   = W_PWM'(sat_abs(64'(u_q), 64'(PWM_MAX)));
         dir_a = !u_neg;
         dir_b = !u_pos;
         integ_new = hold ? integ_q
                          : W_INT'(clamp_s(64'(integ_q) + 64'(err_q), 64'(INT_LIM)));
      end
   end

endmodule

// File: rtl/pid_multi_ctrl.sv
// Multi-channel PI motor controller: Avalon-MM register file, tick prescaler
// and a sweep FSM time-sharing one datapath across all channels.
//   state | meaning
//   IDLE  | waiting for a tick
//   LOAD  | latch setpoint, measurement, gains, integrator of channel ch
//   MUL   | form products
//   SUM   | sum, shift
//   WRITE | commit pwm/dir/integrator of ch, advance or finish sweep
module pid_multi_ctrl import pid_pkg::*; #(
   parameter int N_CH          = 4,
   parameter int W_RPM         = 16,
   parameter int W_PWM         = 8,
   parameter int PWM_MAX       = 249,
   parameter int W_INT         = 32,
   parameter int INT_LIM       = 1048576,
   parameter int FRAC          = 8,
   parameter int PRESC_DEFAULT = 50000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_CH*W_RPM-1:0]   rpm_meas,
   input  logic [5:0]              avs_address,
   input  logic                    avs_write,
   input  logic [31:0]             avs_writedata,
   input  logic                    avs_read,
   output logic [31:0]             avs_readdata,
   output logic [N_CH*W_PWM-1:0]   pwm_cmd,
   output logic [N_CH-1:0]         dir_a,
   output logic [N_CH-1:0]         dir_b,
   output logic                    update_pulse
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                    enable, overrun;
   logic [15:0]             presc, presc_eff, cnt;
   logic                    tick;
   logic signed [W_RPM-1:0] sp_r    [N_CH];
   logic signed [15:0]      kp_r    [N_CH];
   logic signed [15:0]      ki_r    [N_CH];
   logic signed [W_INT-1:0] integ_r [N_CH];
   state_t                  state;
   logic [CW-1:0]           ch;

   logic [5:0]  rel;
   logic [3:0]  ch_sel;
   logic        ch_hit;
   logic [31:0] rd_mux;

   assign rel       = avs_address - 6'(CH_BASE);
   assign ch_sel    = rel[5:2];
   assign ch_hit    = (avs_address >= 6'(CH_BASE)) && (int'(ch_sel) < N_CH);
   assign presc_eff = (presc == '0) ? 16'd1 : presc;
   assign tick      = enable && (cnt >= presc_eff - 16'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (!enable || tick)
         cnt <= '0;
      else
         cnt <= cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable  <= 1'b0;
         presc   <= 16'(PRESC_DEFAULT);
         overrun <= 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            sp_r[c] <= '0;
            kp_r[c] <= '0;
            ki_r[c] <= '0;
         end
      end else begin
         if (avs_write && avs_address == 6'(ADDR_CTRL)) begin
            enable <= avs_writedata[0];
            presc  <= avs_writedata[31:16];
         end
         if (tick && state != IDLE)
            overrun <= 1'b1;
         else if (avs_write && avs_address == 6'(ADDR_STATUS) && avs_writedata[1])
            overrun <= 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            if (avs_write && ch_hit && ch_sel == 4'(c)) begin
               case (rel[1:0])
                  OFS_SP:  sp_r[c] <= avs_writedata[W_RPM-1:0];
                  OFS_KP:  kp_r[c] <= avs_writedata[15:0];
                  OFS_KI:  ki_r[c] <= avs_writedata[15:0];
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      if (avs_address == 6'(ADDR_CTRL))
         rd_mux = {presc, 15'd0, enable};
      else if (avs_address == 6'(ADDR_STATUS))
         rd_mux = {30'd0, overrun, state != IDLE};
      for (int c = 0; c < N_CH; c++) begin
         if (ch_hit && ch_sel == 4'(c)) begin
            case (rel[1:0])
               OFS_SP:  rd_mux = 32'(sp_r[c]);
               OFS_KP:  rd_mux = 32'(kp_r[c]);
               OFS_KI:  rd_mux = 32'(ki_r[c]);
               default: rd_mux = 32'(integ_r[c]);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         avs_readdata <= '0;
      else if (avs_read)
         avs_readdata <= rd_mux;
   end

   logic signed [W_RPM-1:0] meas_sel;
   logic [W_PWM-1:0]        dp_pwm;
   logic                    dp_dir_a, dp_dir_b;
   logic signed [W_INT-1:0] dp_integ;

   assign meas_sel = rpm_meas[int'(ch)*W_RPM +: W_RPM];

   pid_ch_datapath #(
      .W_RPM(W_RPM), .W_PWM(W_PWM), .PWM_MAX(PWM_MAX),
      .W_INT(W_INT), .INT_LIM(INT_LIM), .FRAC(FRAC)
   ) u_dp (
      .clk       (clk),
      .reset_n   (reset_n),
      .ld_en     (state == LOAD),
      .mul_en    (state == MUL),
      .sum_en    (state == SUM),
      .sp        (sp_r[ch]),
      .meas      (meas_sel),
      .kp        (kp_r[ch]),
      .ki        (ki_r[ch]),
      .integ     (integ_r[ch]),
      .pwm       (dp_pwm),
      .dir_a     (dp_dir_a),
      .dir_b     (dp_dir_b),
      .integ_new (dp_integ)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         ch           <= '0;
         pwm_cmd      <= '0;
         dir_a        <= '1;
         dir_b        <= '1;
         update_pulse <= 1'b0;
         for (int c = 0; c < N_CH; c++) integ_r[c] <= '0;
      end else begin
         update_pulse <= 1'b0;
         if (!enable) begin
            // disabled: brake every channel and forget accumulated error
            state   <= IDLE;
            ch      <= '0;
            pwm_cmd <= '0;
            dir_a   <= '1;
            dir_b   <= '1;
            for (int c = 0; c < N_CH; c++) integ_r[c] <= '0;
         end else begin
            case (state)
               IDLE: if (tick) begin
                  state <= LOAD;
                  ch    <= '0;
               end
               LOAD:  state <= MUL;
               MUL:   state <= SUM;
               SUM:   state <= WRITE;
               WRITE: begin
                  pwm_cmd[int'(ch)*W_PWM +: W_PWM] <= dp_pwm;
                  dir_a[ch]   <= dp_dir_a;
                  dir_b[ch]   <= dp_dir_b;
                  integ_r[ch] <= dp_integ;
                  if (ch == CW'(N_CH - 1)) begin
                     state        <= IDLE;
                     update_pulse <= 1'b1;
                  end else begin
                     ch    <= ch + CW'(1);
                     state <= LOAD;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pid_multi_ctrl.sv
// Directed bench for pid_multi_ctrl: hand-computed sweeps over four channels
// covering proportional drive, saturation, brake, anti-windup, overrun, reset.
module tb_pid_multi_ctrl;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] rpm_meas;
   logic [5:0]  avs_address = '0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic [31:0] pwm_cmd;
   logic [3:0]  dir_a, dir_b;
   logic        update_pulse;

   int total = 0;
   int bad   = 0;

   pid_multi_ctrl dut (
      .clk(clk), .reset_n(reset_n), .rpm_meas(rpm_meas),
      .avs_address(avs_address), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_read(avs_read),
      .avs_readdata(avs_readdata), .pwm_cmd(pwm_cmd),
      .dir_a(dir_a), .dir_b(dir_b), .update_pulse(update_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(posedge clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      avs_address = a; avs_read = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic wait_pulse(input int bound, output int n, output logic found);
      found = 1'b0;
      n = 0;
      for (int i = 1; i <= bound && !found; i++) begin
         @(posedge clk); #1;
         if (update_pulse) begin
            found = 1'b1;
            n = i;
         end
      end
   endtask

   initial begin
      logic [31:0] d;
      int          n;
      logic        f;

      rpm_meas = {16'd0, 16'hFFE2, 16'd0, 16'd0};   // meas2 = -30

      #22;
      chk("rst_pwm", pwm_cmd, 32'h0);
      chk("rst_dir_a", 32'(dir_a), 32'hF);
      chk("rst_dir_b", 32'(dir_b), 32'hF);
      chk("rst_pulse", 32'(update_pulse), 32'h0);
      chk("rst_readdata", avs_readdata, 32'h0);
      reset_n = 1'b1;

      rd(6'd0, d);  chk("rst_ctrl", d, 32'hC350_0000);
      rd(6'd1, d);  chk("rst_status", d, 32'h0);

      wr(6'd8,  32'd100);        wr(6'd9,  32'd256);
      wr(6'd12, 32'hFFFF_FC18);  wr(6'd13, 32'd256);
      wr(6'd16, 32'd50);
      wr(6'd22, 32'd256);        wr(6'd20, 32'd1000);
      rd(6'd12, d); chk("sp1_signext", d, 32'hFFFF_FC18);
      rd(6'd2,  d); chk("unmapped_2", d, 32'h0);
      rd(6'd24, d); chk("unmapped_ch4", d, 32'h0);

      // sweep 1
      wr(6'd0, 32'h0064_0001);
      wait_pulse(200, n, f);
      chk("tick_to_pulse", 32'(n), 32'd116);
      @(posedge clk); #1;
      chk("pulse_width", 32'(update_pulse), 32'h0);
      chk("s1_pwm", pwm_cmd, 32'h0000_F964);
      chk("s1_dir_a", 32'(dir_a), 32'hD);
      chk("s1_dir_b", 32'(dir_b), 32'hE);
      rd(6'd0,  d); chk("ctrl_rb", d, 32'h0064_0001);
      rd(6'd11, d); chk("s1_integ0", d, 32'd100);
      rd(6'd15, d); chk("s1_integ1_frozen", d, 32'd0);
      rd(6'd19, d); chk("s1_integ2", d, 32'd80);
      rd(6'd23, d); chk("s1_integ3", d, 32'd1000);

      // sweep 2
      wait_pulse(300, n, f);
      chk("s2_pulse_seen", 32'(f), 32'h1);
      chk("s2_pwm", pwm_cmd, 32'hF900_F964);
      chk("s2_dir_a", 32'(dir_a), 32'hD);
      chk("s2_dir_b", 32'(dir_b), 32'h6);
      rd(6'd19, d); chk("s2_integ2", d, 32'd160);
      rd(6'd23, d); chk("s2_integ3_frozen", d, 32'd1000);

      // sweep 3: setpoint 2 to zero brakes and clears channel 2
      wr(6'd16, 32'd0);
      wait_pulse(300, n, f);
      chk("s3_pulse_seen", 32'(f), 32'h1);
      chk("s3_pwm", pwm_cmd, 32'hF900_F964);
      chk("s3_dir_a", 32'(dir_a), 32'hD);
      chk("s3_dir_b", 32'(dir_b), 32'h6);
      rd(6'd19, d); chk("s3_integ2_clear", d, 32'd0);
      rd(6'd11, d); chk("s3_integ0", d, 32'd300);
      rd(6'd23, d); chk("s3_integ3_frozen", d, 32'd1000);

      // overrun with a 3-cycle tick
      wr(6'd0, 32'h0003_0001);
      wait_pulse(60, n, f);
      chk("ovr_pulse_seen", 32'(f), 32'h1);
      rd(6'd1, d);  chk("ovr_sticky", 32'(d[1]), 32'h1);
      wr(6'd0, 32'h0064_0001);
      wait_pulse(250, n, f);
      chk("ovr_drain_pulse", 32'(f), 32'h1);
      wr(6'd1, 32'h2);
      rd(6'd1, d);  chk("ovr_cleared", d, 32'h0);

      // disable
      wr(6'd0, 32'h0064_0000);
      @(posedge clk); #1;
      chk("dis_pwm", pwm_cmd, 32'h0);
      chk("dis_dir_a", 32'(dir_a), 32'hF);
      chk("dis_dir_b", 32'(dir_b), 32'hF);
      rd(6'd11, d); chk("dis_integ0", d, 32'h0);
      rd(6'd23, d); chk("dis_integ3", d, 32'h0);
      rd(6'd9,  d); chk("dis_kp0_kept", d, 32'h100);
      rd(6'd0,  d); chk("dis_ctrl", d, 32'h0064_0000);

      // async reset during MUL of channel 1
      wr(6'd0, 32'h0005_0001);
      repeat (10) @(posedge clk);
      #1;
      chk("mid_pwm0", pwm_cmd, 32'h0000_0064);
      chk("mid_dir_b", 32'(dir_b), 32'hE);
      reset_n = 1'b0;
      #1;
      chk("ar_pwm", pwm_cmd, 32'h0);
      chk("ar_dir_a", 32'(dir_a), 32'hF);
      chk("ar_dir_b", 32'(dir_b), 32'hF);
      chk("ar_pulse", 32'(update_pulse), 32'h0);
      chk("ar_readdata", avs_readdata, 32'h0);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      avs_address = 6'd0; avs_read = 1'b1;
      #1;
      chk("ar_rd_latency", avs_readdata, 32'h0);
      @(posedge clk); #1;
      avs_read = 1'b0;
      chk("ar_ctrl", avs_readdata, 32'hC350_0000);
      @(posedge clk); #1;
      chk("ar_rd_hold", avs_readdata, 32'hC350_0000);
      rd(6'd1, d); chk("ar_status", d, 32'h0);
      rd(6'd9, d); chk("ar_kp0", d, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
